// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings, default baud divisor, data width.
// The optional even-parity frame format is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam int CLKS_PER_BIT_9600 = 5000;
    localparam int DATA_BITS         = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
        end
    end

    assign rx_s = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, mid-bit sampling, valid/ready output with overrun/frame/parity flags.
// Define UART_RX_PARITY_EN for start + 8 data + even parity + stop; otherwise plain 8N1.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_reg,      state_next;
    logic [15:0]          bit_cnt_reg,    bit_cnt_next;
    logic [2:0]           bit_idx_reg,    bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg,      shift_next;
    logic [7:0]           rx_data_reg,    rx_data_next;
    logic                 rx_valid_reg,   rx_valid_next;
    logic                 frame_err_reg,  frame_err_next;
    logic                 overrun_reg,    overrun_next;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_reg, parity_err_next;
    logic                 par_bad_reg,    par_bad_next;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
            par_bad_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_err_next;
            par_bad_reg    <= par_bad_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        rx_data_next    = rx_data_reg;
        rx_valid_next   = rx_valid_reg;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_next = 1'b0;
        par_bad_next    = par_bad_reg;
`endif

        // A byte load later in this block overrides the clear, so accept+load keeps valid high.
        if (rx_valid_reg && rx_ready) begin
            rx_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    bit_cnt_next = HALF_LOAD;
                    state_next   = ST_START;
                end
            end

            ST_START: begin
                if (bit_cnt_reg == 16'd0) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        bit_cnt_next = FULL_LOAD;
                        bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_next = 1'b0;
`endif
                        state_next   = ST_DATA;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end

            ST_DATA: begin
                if (bit_cnt_reg == 16'd0) begin
                    shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                    bit_cnt_next = FULL_LOAD;
                    if (bit_idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_cnt_reg == 16'd0) begin
                    par_bad_next = rx_s ^ even_parity(shift_reg);
                    bit_cnt_next = FULL_LOAD;
                    state_next   = ST_STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
`endif

            ST_STOP: begin
                if (bit_cnt_reg == 16'd0) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_reg) begin
                            parity_err_next = 1'b1;
                        end else begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                            overrun_next  = rx_valid_reg && !rx_ready;
                        end
`else
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                        overrun_next  = rx_valid_reg && !rx_ready;
`endif
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_WAIT_HIGH;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end

            // A held-low line (break) must return high before another start bit is hunted.
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule
